mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Load/store sequencer for the MEM stage. It accepts one memory request at a time from the pipeline and drives a word-only data memory.
- For loads: extracts the addressed byte or halfword, then sign- or zero-extends it.
- Sub-word stores use read-modify-write (RMW) when the memory has no byte enables.
- Flags misaligned accesses. Holds the pipeline via req_ready/busy until the access completes.

Parameters:
- RD_LAT, 1, memory read latency in cycles from read-issue cycle to the mem_rdata-valid cycle (legal 1..4).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_op  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; SB uses [7:0], SH uses [15:0].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and faults.
- resp_misalign  out  1  qualifies resp_valid; access was misaligned.
- busy  out  1  state != IDLE.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write when mem_en.
- mem_be  out  4  byte write enables.
- mem_addr  out  32  word address {req_addr[31:2],2'b00}.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid RD_LAT cycles after read issue.

Behaviour:
- Reset: synchronous while rst_n=0 → state IDLE.
  - Outputs during reset: req_ready=0, resp_valid=0, resp_rdata=0, resp_misalign=0, busy=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation abandons the access with no response. An RMW write not yet issued is never issued.
- Lane mapping is little-endian:
  - Byte k = D[8k+7:8k], k=addr[1:0].
  - Half = addr[1] ? D[31:16] : D[15:0].
- Alignment:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - Bytes are always aligned.
- Accept: req_valid&&req_ready in cycle T0 latches op/addr/wdata.
- States: IDLE, RD_ISSUE, RD_WAIT, WRITE, RESP.
- Misaligned request: IDLE→RESP. No mem_en at any point. In T1: resp_valid=1, resp_misalign=1, resp_rdata=0.
- Loads: T1 RD_ISSUE (mem_en=1, mem_we=0). Then RD_WAIT for RD_LAT cycles; mem_rdata is sampled at the end of the last cycle. Then RESP with the extended value.
  - RD_LAT=1: resp_valid in T3.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- SW: T1 WRITE (mem_en=1, mem_we=1, mem_be=4'hF, mem_wdata=req_wdata). T2 RESP.
- SB/SH without the optional feature (RMW):
  - RD_ISSUE, then RD_WAIT; the read word is captured into a merge register.
  - Merge replaces only the addressed lane(s) with req_wdata[7:0] or [15:0].
  - WRITE with mem_be=4'hF, then RESP.
  - RD_LAT=1: resp_valid in T4.
- RESP lasts exactly one cycle and returns to IDLE. req_ready=0 in RESP, so the earliest next accept is the cycle after the resp_valid pulse.
- resp_valid has no backpressure.
- mem_en=0 in IDLE and RESP. mem_addr and mem_wdata hold their last values when mem_en=0.
- req_valid while busy is ignored; the requester must hold it until accepted.

Optional Feature:
- Macro: MEM_BYTE_WE_EN.
- Defined: SB/SH skip the read entirely. They go straight to WRITE with:
  - mem_be = 4'b0001<<addr[1:0] for SB, addr[1] ? 4'b1100 : 4'b0011 for SH.
  - mem_wdata = byte replicated ×4 for SB, half replicated ×2 for SH.
  - Latency is identical to SW.
- Undefined: mem_be is always 4'hF when writing and 0 otherwise; sub-word stores use RMW.

Test Plan:
- Memory word 0x80FF7F01 at 0x100, RD_LAT=1. Run LB 0x103, LBU 0x103, LB 0x100, LH 0x102, LHU 0x102, LW 0x100 → resp_rdata 0xFFFFFF80, 0x00000080, 0x00000001, 0xFFFF80FF, 0x000080FF, 0x80FF7F01. Each resp_valid arrives 3 cycles after accept.
- SB 0x101 data 0xAA onto 0x11223344, macro off → one read, then write 0x1122AA44 with mem_be=F. resp_valid 4 cycles after accept.
- Same SB with MEM_BYTE_WE_EN → no read, single write with mem_be=4'b0010 and mem_wdata=0xAAAAAAAA. resp_valid 2 cycles after accept.
- LH 0x101 and SW 0x102 → resp_valid with resp_misalign=1 one cycle after accept, no mem_en asserted.
- Assert rst_n=0 during RD_WAIT of an SH → no write issued, no resp_valid, all outputs 0. req_ready=1 in the first cycle after rst_n returns high.
- RD_LAT=3, LW 0x200 holding 0xDEADBEEF → resp_valid 5 cycles after accept with 0xDEADBEEF. req_valid held during busy is accepted only after RESP.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer for a word-only data memory.
// Accepts one request at a time (req_valid/req_ready), extracts and extends
// loaded bytes/halfwords, flags misaligned accesses, and performs sub-word
// stores by read-modify-write.
// Optional build macro MEM_BYTE_WE_EN: memory has byte write enables, so SB/SH
// are issued as a single masked write with lane-replicated data.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_op/req_addr/req_wdata   operation, byte address, store data
//   resp_valid/resp_rdata       one-cycle completion pulse and load result
//   resp_misalign               completion was a misaligned-access fault
//   busy                        controller not in IDLE
//   mem_en/mem_we/mem_be        memory strobe, write, byte enables
//   mem_addr/mem_wdata          word address and write data (held when idle)
//   mem_rdata                   read data, valid RD_LAT cycles after issue
module mem_access_ctrl #(
   parameter int unsigned RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_misalign,
   output logic        busy,
   output logic        mem_en,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LW  = 3'b010;
   localparam logic [2:0] OP_LBU = 3'b011;
   localparam logic [2:0] OP_LHU = 3'b100;
   localparam logic [2:0] OP_SB  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;
   localparam logic [2:0] OP_SW  = 3'b111;

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WRITE, RESP} state_t;

   state_t      state, state_next;
   logic [2:0]  op_q;
   logic [1:0]  addr_lo_q;
   logic        misalign_q;
   logic [1:0]  lat_cnt;
   logic [31:0] rdata_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;

   logic        req_misalign;
   logic        req_is_load;
   logic        op_is_load;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_ext;
   logic [3:0]  write_be;
`ifndef MEM_BYTE_WE_EN
   logic [15:0] wdata_q;
   logic [31:0] merged;
`endif

   assign req_is_load = (req_op <= OP_LHU);
   assign op_is_load  = (op_q <= OP_LHU);

   always_comb begin
      req_misalign = 1'b0;
      case (req_op)
         OP_LH, OP_LHU, OP_SH: req_misalign = req_addr[0];
         OP_LW, OP_SW:         req_misalign = |req_addr[1:0];
         default:              req_misalign = 1'b0;
      endcase
   end

   // Little-endian lane extraction and extension of the returned word
   always_comb begin
      rd_byte  = mem_rdata[8*addr_lo_q +: 8];
      rd_half  = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_ext = mem_rdata;
      case (op_q)
         OP_LB:   load_ext = {{24{rd_byte[7]}}, rd_byte};
         OP_LBU:  load_ext = {24'h0, rd_byte};
         OP_LH:   load_ext = {{16{rd_half[15]}}, rd_half};
         OP_LHU:  load_ext = {16'h0, rd_half};
         default: load_ext = mem_rdata;
      endcase
   end

`ifndef MEM_BYTE_WE_EN
   always_comb begin
      merged = mem_rdata;
      if (op_q == OP_SB)
         merged[8*addr_lo_q +: 8] = wdata_q[7:0];
      else if (addr_lo_q[1])
         merged[31:16] = wdata_q;
      else
         merged[15:0] = wdata_q;
   end

   assign write_be = 4'hF;
`else
   always_comb begin
      write_be = 4'hF;
      case (op_q)
         OP_SB:   write_be = 4'b0001 << addr_lo_q;
         OP_SH:   write_be = addr_lo_q[1] ? 4'b1100 : 4'b0011;
         default: write_be = 4'hF;
      endcase
   end
`endif

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_misalign)
                  state_next = RESP;
               else if (req_is_load)
                  state_next = RD_ISSUE;
               else if (req_op == OP_SW)
                  state_next = WRITE;
               else
`ifdef MEM_BYTE_WE_EN
                  state_next = WRITE;
`else
                  state_next = RD_ISSUE;
`endif
            end
         end
         RD_ISSUE: state_next = RD_WAIT;
         RD_WAIT:  if (lat_cnt == 2'd0) state_next = op_is_load ? RESP : WRITE;
         WRITE:    state_next = RESP;
         RESP:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         op_q        <= '0;
         addr_lo_q   <= '0;
         misalign_q  <= 1'b0;
         lat_cnt     <= '0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifndef MEM_BYTE_WE_EN
         wdata_q     <= '0;
`endif
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q       <= req_op;
                  addr_lo_q  <= req_addr[1:0];
                  misalign_q <= req_misalign;
                  rdata_q    <= '0;
`ifndef MEM_BYTE_WE_EN
                  wdata_q    <= req_wdata[15:0];
`endif
                  // Memory-facing registers only move when an access will follow
                  if (!req_misalign) begin
                     mem_addr_q <= {req_addr[31:2], 2'b00};
                     if (req_op == OP_SW)
                        mem_wdata_q <= req_wdata;
`ifdef MEM_BYTE_WE_EN
                     else if (req_op == OP_SB)
                        mem_wdata_q <= {4{req_wdata[7:0]}};
                     else if (req_op == OP_SH)
                        mem_wdata_q <= {2{req_wdata[15:0]}};
`endif
                  end
               end
            end
            RD_ISSUE: lat_cnt <= LAT_LAST;
            RD_WAIT: begin
               if (lat_cnt != 2'd0)
                  lat_cnt <= lat_cnt - 2'd1;
               else if (op_is_load)
                  rdata_q <= load_ext;
`ifndef MEM_BYTE_WE_EN
               else
                  mem_wdata_q <= merged;
`endif
            end
            default: ;
         endcase
      end
   end

   // Outputs are forced low while reset is asserted, even before the first edge
   assign req_ready     = rst_n && (state == IDLE);
   assign busy          = rst_n && (state != IDLE);
   assign resp_valid    = rst_n && (state == RESP);
   assign resp_misalign = resp_valid && misalign_q;
   assign resp_rdata    = resp_valid ? rdata_q : '0;
   assign mem_en        = rst_n && ((state == RD_ISSUE) || (state == WRITE));
   assign mem_we        = rst_n && (state == WRITE);
   assign mem_be        = mem_we ? write_be : '0;
   assign mem_addr      = rst_n ? mem_addr_q : '0;
   assign mem_wdata     = rst_n ? mem_wdata_q : '0;

endmodule
